// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and saturating BCD step functions for the stopwatch.
package stopwatch_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, LIMIT} state_t;

   localparam logic [3:0]  D0_MAX  = 4'd9;
   localparam logic [3:0]  D1_MAX  = 4'd9;
   localparam logic [3:0]  D2_MAX  = 4'd5;
   localparam logic [3:0]  D3_MAX  = 4'd9;
   localparam logic [15:0] CNT_MAX = {D3_MAX, D2_MAX, D1_MAX, D0_MAX};
   localparam logic [15:0] CNT_MIN = 16'h0000;

   // Both functions saturate at the ends so the count can never wrap.
   function automatic logic [15:0] bcd_inc(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c != CNT_MAX) begin
         if (c[3:0] != D0_MAX) r[3:0] = c[3:0] + 4'd1;
         else begin
            r[3:0] = 4'd0;
            if (c[7:4] != D1_MAX) r[7:4] = c[7:4] + 4'd1;
            else begin
               r[7:4] = 4'd0;
               if (c[11:8] != D2_MAX) r[11:8] = c[11:8] + 4'd1;
               else begin
                  r[11:8]  = 4'd0;
                  r[15:12] = c[15:12] + 4'd1;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c != CNT_MIN) begin
         if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
         else begin
            r[3:0] = D0_MAX;
            if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
            else begin
               r[7:4] = D1_MAX;
               if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
               else begin
                  r[11:8]  = D2_MAX;
                  r[15:12] = c[15:12] - 4'd1;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Tenth-second prescaler: tick is high combinationally on the last count of each period.
module tick_gen #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         r_cnt <= '0;
      else if (en)
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
   end

   assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button edge commands, run/pause/limit FSM, BCD count and lap freeze.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_lap,
   input  logic       up,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic       running,
   output logic       at_limit,
   output logic       lap_active
);

   state_t      r_state;
   logic        r_start_q, r_clear_q, r_lap_q;
   logic [15:0] r_cnt, r_lap_val;
   logic        r_running, r_at_limit, r_lap_active;

   logic        w_cmd_clear, w_cmd_start, w_cmd_lap;
   logic        w_tick, w_presc_clr, w_presc_en;
   logic        w_start_blocked, w_tick_limit;
   logic [15:0] w_cnt_next;

   // One command per cycle: clear beats start beats lap.
   assign w_cmd_clear = btn_clear & ~r_clear_q;
   assign w_cmd_start = btn_start & ~r_start_q & ~w_cmd_clear;
   assign w_cmd_lap   = btn_lap & ~r_lap_q & ~w_cmd_clear & ~w_cmd_start;

   assign w_presc_clr     = w_cmd_clear | w_cmd_start;
   assign w_presc_en      = (r_state == RUN);
   assign w_start_blocked = up ? (r_cnt == CNT_MAX) : (r_cnt == CNT_MIN);
   assign w_cnt_next      = up ? bcd_inc(r_cnt) : bcd_dec(r_cnt);
   assign w_tick_limit    = up ? (w_cnt_next == CNT_MAX) : (w_cnt_next == CNT_MIN);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_presc_clr),
      .en   (w_presc_en),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_start_q    <= 1'b0;
         r_clear_q    <= 1'b0;
         r_lap_q      <= 1'b0;
         r_cnt        <= CNT_MIN;
         r_lap_val    <= CNT_MIN;
         r_running    <= 1'b0;
         r_at_limit   <= 1'b0;
         r_lap_active <= 1'b0;
      end else begin
         r_start_q <= btn_start;
         r_clear_q <= btn_clear;
         r_lap_q   <= btn_lap;
         if (w_cmd_clear) begin
            r_state      <= IDLE;
            r_cnt        <= CNT_MIN;
            r_running    <= 1'b0;
            r_at_limit   <= 1'b0;
            r_lap_active <= 1'b0;
         end else if (w_cmd_start) begin
            if (r_state == RUN) begin
               r_state      <= PAUSE;
               r_running    <= 1'b0;
               r_lap_active <= 1'b0;
            end else if (w_start_blocked) begin
               r_state      <= LIMIT;
               r_running    <= 1'b0;
               r_at_limit   <= 1'b1;
               r_lap_active <= 1'b0;
            end else begin
               r_state    <= RUN;
               r_running  <= 1'b1;
               r_at_limit <= 1'b0;
            end
         end else begin
            if (w_cmd_lap) begin
               if (r_state == RUN) begin
                  r_lap_active <= ~r_lap_active;
                  if (!r_lap_active) r_lap_val <= r_cnt;
               end else begin
                  r_lap_active <= 1'b0;
               end
            end
            // A tick reaching the end saturates here; the later lap clear overrides any toggle.
            if (w_tick) begin
               r_cnt <= w_cnt_next;
               if (w_tick_limit) begin
                  r_state      <= LIMIT;
                  r_running    <= 1'b0;
                  r_at_limit   <= 1'b1;
                  r_lap_active <= 1'b0;
               end
            end
         end
      end
   end

   assign {d3, d2, d1, d0} = r_lap_active ? r_lap_val : r_cnt;
   assign running          = r_running;
   assign at_limit         = r_at_limit;
   assign lap_active       = r_lap_active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expectations queued then compared.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic       up = 1'b1;
   logic [3:0] d3, d2, d1, d0;
   logic       running, at_limit, lap_active;

   typedef struct {
      string       tag;
      logic [18:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_clear  (btn_clear),
      .btn_lap    (btn_lap),
      .up         (up),
      .d3         (d3),
      .d2         (d2),
      .d1         (d1),
      .d0         (d0),
      .running    (running),
      .at_limit   (at_limit),
      .lap_active (lap_active)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int t);
      logic [15:0] r;
      r[15:12] = 4'(t / 600);
      r[11:8]  = 4'((t % 600) / 100);
      r[7:4]   = 4'((t % 100) / 10);
      r[3:0]   = 4'(t % 10);
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // which: 0 start, 1 clear, 2 lap
   task automatic press(input int which);
      case (which)
         0: btn_start = 1'b1;
         1: btn_clear = 1'b1;
         default: btn_lap = 1'b1;
      endcase
      step(1);
      btn_start = 1'b0;
      btn_clear = 1'b0;
      btn_lap   = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int t, input logic run, input logic lim,
                             input logic lap);
      exp_t e;
      e.tag = tag;
      e.val = {to_bcd(t), run, lim, lap};
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t        e;
      logic [18:0] obs;
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard: observed output with no expectation queued");
         return;
      end
      e   = sb.pop_front();
      obs = {d3, d2, d1, d0, running, at_limit, lap_active};
      assert (obs === e.val) else begin
         n_err++;
         $error("FAIL %s: observed digits=%h run/lim/lap=%b%b%b, expected digits=%h run/lim/lap=%b%b%b",
                e.tag, obs[18:3], obs[2], obs[1], obs[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
   endtask

   initial begin
      step(2);
      expect_out("reset", 0, 1'b0, 1'b0, 1'b0);
      check_out();
      rst = 1'b0;
      step(1);

      up = 1'b1;
      expect_out("start_run", 0, 1'b1, 1'b0, 1'b0);
      press(0);
      check_out();
      expect_out("pre_tick", 0, 1'b1, 1'b0, 1'b0);
      step(3);
      check_out();
      expect_out("first_tick", 1, 1'b1, 1'b0, 1'b0);
      step(1);
      check_out();
      expect_out("third_tick", 3, 1'b1, 1'b0, 1'b0);
      step(8);
      check_out();
      expect_out("pause", 3, 1'b0, 1'b0, 1'b0);
      press(0);
      check_out();
      expect_out("pause_hold", 3, 1'b0, 1'b0, 1'b0);
      step(10);
      check_out();

      expect_out("preload_59_9", 599, 1'b1, 1'b0, 1'b0);
      press(0);
      step(4 * 596);
      check_out();
      expect_out("carry_to_min", 600, 1'b1, 1'b0, 1'b0);
      step(4);
      check_out();
      expect_out("limit_up", 5999, 1'b0, 1'b1, 1'b0);
      step(4 * 5399);
      check_out();
      expect_out("start_at_max", 5999, 1'b0, 1'b1, 1'b0);
      press(0);
      check_out();

      expect_out("clear_max", 0, 1'b0, 1'b0, 1'b0);
      press(1);
      check_out();
      step(1);
      expect_out("run_to_1min", 600, 1'b1, 1'b0, 1'b0);
      press(0);
      step(2400);
      check_out();
      up = 1'b0;
      expect_out("borrow", 599, 1'b1, 1'b0, 1'b0);
      step(4);
      check_out();
      expect_out("limit_down", 0, 1'b0, 1'b1, 1'b0);
      step(4 * 599);
      check_out();
      expect_out("start_down_at0", 0, 1'b0, 1'b1, 1'b0);
      press(0);
      check_out();

      up = 1'b1;
      step(1);
      expect_out("clear_zero", 0, 1'b0, 1'b0, 1'b0);
      press(1);
      check_out();
      step(1);
      expect_out("lap_base", 23, 1'b1, 1'b0, 1'b0);
      press(0);
      step(92);
      check_out();
      expect_out("lap_freeze", 23, 1'b1, 1'b0, 1'b1);
      press(2);
      check_out();
      expect_out("lap_frozen", 23, 1'b1, 1'b0, 1'b1);
      step(20);
      check_out();
      expect_out("lap_release", 28, 1'b1, 1'b0, 1'b0);
      press(2);
      check_out();
      step(1);
      expect_out("lap_on_tick", 28, 1'b1, 1'b0, 1'b1);
      press(2);
      check_out();
      expect_out("lap_still_frozen", 28, 1'b1, 1'b0, 1'b1);
      step(4);
      check_out();
      expect_out("lap_live", 30, 1'b1, 1'b0, 1'b0);
      press(2);
      check_out();

      btn_start = 1'b1;
      btn_lap   = 1'b1;
      btn_clear = 1'b1;
      expect_out("all_cmds", 0, 1'b0, 1'b0, 1'b0);
      step(1);
      check_out();
      expect_out("all_held", 0, 1'b0, 1'b0, 1'b0);
      step(10);
      check_out();
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clear = 1'b0;
      step(1);

      btn_start = 1'b1;
      expect_out("start_held", 3, 1'b1, 1'b0, 1'b0);
      step(13);
      check_out();
      btn_start = 1'b0;
      step(1);

      press(1);
      step(1);
      expect_out("run_to_4_5", 45, 1'b1, 1'b0, 1'b0);
      press(0);
      step(180);
      check_out();
      rst = 1'b1;
      expect_out("rst_mid_run", 0, 1'b0, 1'b0, 1'b0);
      step(1);
      check_out();
      rst = 1'b0;
      expect_out("rst_restart_pre", 0, 1'b1, 1'b0, 1'b0);
      press(0);
      step(3);
      check_out();
      expect_out("rst_restart_tick", 1, 1'b1, 1'b0, 1'b0);
      step(1);
      check_out();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and sequencing block for the 4-digit BCD stopwatch datapath (format M:SS.t, max 9:59.9). It turns raw button levels into single-cycle commands, gates a prescaled time-base tick, and steps the BCD digit chain up or down with saturation. It also provides a lap-freeze display register. It sits between the board button inputs and the seven-segment display driver.

## Interface
- TICK_DIV, default 5_000_000, clk cycles per tenth-second tick (≥2); benches use 4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  start/pause toggle, level input, acts on rising edge
- btn_clear  in  1  clear, level input, acts on rising edge
- btn_lap  in  1  lap freeze/release toggle, level input, acts on rising edge
- up  in  1  count direction: 1 counts up, 0 counts down; sampled at each tick
- d3  out  4  displayed minutes, 0-9
- d2  out  4  displayed tens of seconds, 0-5
- d1  out  4  displayed seconds, 0-9
- d0  out  4  displayed tenths, 0-9
- running  out  1  high in RUN
- at_limit  out  1  high in LIMIT
- lap_active  out  1  high while the display is frozen

## Operation
- Edge detect: register each button; command = btn & ~btn_q. One command is processed per edge, priority clear > start > lap; lower-priority commands in the same cycle are dropped.
- Internal count cnt = {c3,c2,c1,c0}. Display = lap register when lap_active, else cnt.
- States:
  - IDLE: stopped, cnt = 0.
  - RUN: counting.
  - PAUSE: stopped, cnt ≠ 0 or previously run.
  - LIMIT: saturated and stopped.
- Start in IDLE/PAUSE/LIMIT:
  - If up=1 and cnt=9599, or up=0 and cnt=0000, go to (or stay in) LIMIT.
  - Otherwise go to RUN and restart the prescaler.
- Start in RUN: go to PAUSE and hold the prescaler at 0.
- Clear in any state:
  - Set cnt = 0 and lap_active = 0.
  - Go to IDLE and hold the prescaler at 0.
- Lap:
  - In RUN: toggle lap_active; on 0→1, load the lap register with cnt.
  - In other states: set lap_active = 0 (release only).
- Tick in RUN, up=1: BCD increment. The carry chain is c0 9→0 → c1 9→0 → c2 5→0 → c3. Reaching 9599 moves to LIMIT in the same edge.
- Tick in RUN, up=0: BCD decrement. The borrow chain is c0 0→9 → c1 0→9 → c2 0→5 → c3. Reaching 0000 moves to LIMIT.
- Changing up mid-run takes effect on the next tick. There is no wrap-around ever; cnt never leaves the range 0000..9599 with legal digits.
- Entering LIMIT or PAUSE clears lap_active.

## Timing
- Reset values: d3..d0 = 0, running = 0, at_limit = 0, lap_active = 0. State is IDLE, prescaler = 0, button registers = 0.
- A button rising at edge k (btn=1, btn_q=0) takes effect at edge k; outputs change after edge k.
- A start at edge k zeroes the prescaler. The tick is asserted combinationally when the prescaler = TICK_DIV-1, so the first digit update lands at edge k+TICK_DIV, then every TICK_DIV cycles.
- Pause followed by start restarts the tenth from 0; a partial tenth is discarded.
- Tick and command in the same cycle: the command wins.
  - Start→PAUSE: the tick is ignored.
  - Clear: the tick is ignored.
  - Lap capture: captures cnt before the tick's update.
- rst mid-run behaves like reset in all respects; no residual tick.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum (IDLE, RUN, PAUSE, LIMIT);
  - digit limit constants D0_MAX=9, D1_MAX=9, D2_MAX=5, D3_MAX=9;
  - BCD increment/decrement functions on the 16-bit count.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, clr, en, tick) is the prescaler. clr has priority over en; it counts only when en=1.
- The FSM, edge detectors, count and lap registers live in stopwatch_ctrl.

## Test plan (TICK_DIV=4)
- Reset, then one start pulse with up=1 → running=1. d0 reaches 1 at 4 cycles after start and 3 at 12 cycles. A second start → PAUSE and the digits hold.
- Preload to 0:59.9 by running, then one tick → 1:00.0 (d3=1, d2=0, d1=0, d0=0). Run to 9:59.9 → at_limit=1, running=0. A further start stays in LIMIT.
- From 1:00.0 with up=0, one tick → 0:59.9; run to 0:00.0 → LIMIT. Start with up=0 at 0000 → LIMIT immediately.
- In RUN at 0:02.3, lap → display frozen at 0:02.3 while the internal count advances. Lap again → display shows the live count, e.g. 0:03.1.
- Start, lap and clear asserted in the same cycle mid-run → IDLE, all digits 0, lap_active=0. A held button produces only one command.
- rst asserted mid-run at 0:04.5 → all outputs 0 the next cycle. Start afterward → first tick lands exactly 4 cycles later.
